// File: rtl/dcache_tag_write_stage.sv
// Tag-array write stage: buffers arbitrated tag writes in a small FIFO, issues them
// to the tag SRAM with a parity bit, and flags same-index hazards to the load pipe.
module dcache_tag_write_stage #(
  parameter int IDX_W        = 6,
  parameter int WAYS         = 8,
  parameter int TAG_W        = 24,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  output logic               io_req_ready,
  input  logic               io_req_valid,
  input  logic [IDX_W-1:0]   io_req_bits_idx,
  input  logic [WAYS-1:0]    io_req_bits_way_en,
  input  logic [TAG_W-1:0]   io_req_bits_tag,
  input  logic               io_read_valid,
  input  logic [IDX_W-1:0]   io_read_idx,
  output logic               io_read_ready,
  output logic               io_read_conflict,
  output logic               io_sram_wen,
  output logic [IDX_W-1:0]   io_sram_idx,
  output logic [WAYS-1:0]    io_sram_way_en,
  output logic [TAG_W:0]     io_sram_tag,
  output logic               io_busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  logic [IDX_W-1:0] idx_mem_reg [DEPTH];
  logic [WAYS-1:0]  way_mem_reg [DEPTH];
  logic [TAG_W-1:0] tag_mem_reg [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [SW-1:0]    starve_reg, starve_next;

  logic             sram_wen_reg;
  logic [IDX_W-1:0] sram_idx_reg;
  logic [WAYS-1:0]  sram_way_reg;
  logic [TAG_W:0]   sram_tag_reg;

  logic             head_valid;
  logic             force_write;
  logic             enq;
  logic             deq;
  logic [IDX_W-1:0] head_idx;
  logic [WAYS-1:0]  head_way;
  logic [TAG_W-1:0] head_tag;
  logic [DEPTH-1:0] entry_hit;

  assign head_valid  = (count_reg != '0);
  // Only registered state feeds the read grant, so no io_read_valid -> io_read_ready path.
  assign force_write = (starve_reg == SW'(STARVE_LIMIT));
  assign io_req_ready  = (count_reg != CNT_W'(DEPTH));
  assign io_read_ready = ~force_write;

  assign enq = io_req_valid & io_req_ready;
  assign deq = head_valid & (~io_read_valid | force_write);

  assign head_idx = idx_mem_reg[head_reg];
  assign head_way = way_mem_reg[head_reg];
  assign head_tag = tag_mem_reg[head_reg];

  always_comb begin
    head_next   = head_reg;
    tail_next   = tail_reg;
    count_next  = count_reg;
    starve_next = starve_reg;
    if (enq) tail_next = tail_reg + PTR_W'(1);
    if (deq) head_next = head_reg + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
    if (!head_valid || deq) begin
      starve_next = '0;
    end else if (io_read_valid && !force_write) begin
      starve_next = starve_reg + SW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
    end else begin
      head_reg   <= head_next;
      tail_reg   <= tail_next;
      count_reg  <= count_next;
      starve_reg <= starve_next;
    end
  end

  // Entry storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clock) begin
    if (reset && enq) begin
      idx_mem_reg[tail_reg] <= io_req_bits_idx;
      way_mem_reg[tail_reg] <= io_req_bits_way_en;
      tag_mem_reg[tail_reg] <= io_req_bits_tag;
    end
  end

  // A head with an empty way mask is consumed without touching the SRAM port.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sram_wen_reg <= 1'b0;
      sram_idx_reg <= '0;
      sram_way_reg <= '0;
      sram_tag_reg <= '0;
    end else begin
      sram_wen_reg <= deq && (head_way != '0);
      if (deq && (head_way != '0)) begin
        sram_idx_reg <= head_idx;
        sram_way_reg <= head_way;
        sram_tag_reg <= {^head_tag, head_tag};
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      localparam logic [PTR_W-1:0] SLOT = PTR_W'(gi);
      logic [PTR_W-1:0] offset;
      assign offset        = SLOT - head_reg;
      assign entry_hit[gi] = (CNT_W'(offset) < count_reg) && (idx_mem_reg[gi] == io_read_idx);
    end
  endgenerate

  assign io_read_conflict = io_read_valid &
                            ((|entry_hit) | (sram_wen_reg & (sram_idx_reg == io_read_idx)));

  assign io_sram_wen    = sram_wen_reg;
  assign io_sram_idx    = sram_idx_reg;
  assign io_sram_way_en = sram_way_reg;
  assign io_sram_tag    = sram_tag_reg;
  assign io_busy        = head_valid | sram_wen_reg;

endmodule

// File: tb/tb_dcache_tag_write_stage.sv
// Bench for dcache_tag_write_stage: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dcache_tag_write_stage;
  localparam int IDX_W = 6;
  localparam int WAYS  = 8;
  localparam int TAG_W = 24;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             io_req_ready;
  logic             io_req_valid = 1'b0;
  logic [IDX_W-1:0] io_req_bits_idx = '0;
  logic [WAYS-1:0]  io_req_bits_way_en = '0;
  logic [TAG_W-1:0] io_req_bits_tag = '0;
  logic             io_read_valid = 1'b0;
  logic [IDX_W-1:0] io_read_idx = '0;
  logic             io_read_ready;
  logic             io_read_conflict;
  logic             io_sram_wen;
  logic [IDX_W-1:0] io_sram_idx;
  logic [WAYS-1:0]  io_sram_way_en;
  logic [TAG_W:0]   io_sram_tag;
  logic             io_busy;

  always #5 clock = ~clock;

  dcache_tag_write_stage #(
    .IDX_W(IDX_W), .WAYS(WAYS), .TAG_W(TAG_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock(clock), .reset(reset),
    .io_req_ready(io_req_ready), .io_req_valid(io_req_valid),
    .io_req_bits_idx(io_req_bits_idx), .io_req_bits_way_en(io_req_bits_way_en),
    .io_req_bits_tag(io_req_bits_tag),
    .io_read_valid(io_read_valid), .io_read_idx(io_read_idx),
    .io_read_ready(io_read_ready), .io_read_conflict(io_read_conflict),
    .io_sram_wen(io_sram_wen), .io_sram_idx(io_sram_idx),
    .io_sram_way_en(io_sram_way_en), .io_sram_tag(io_sram_tag),
    .io_busy(io_busy)
  );

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [WAYS-1:0]  way;
    logic [TAG_W-1:0] tag;
  } ent_t;

  // Reference model: a queue of pending writes plus the registered SRAM port.
  ent_t             mq[$];
  int               m_starve = 0;
  bit               m_wen = 1'b0;
  logic [IDX_W-1:0] m_idx = '0;
  logic [WAYS-1:0]  m_way = '0;
  logic [TAG_W:0]   m_tag = '0;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin : compare_proc
    bit   forced, hit, issue, accept;
    ent_t h, e;
    if (check_en) begin
      forced = (m_starve == LIMIT);
      hit = 1'b0;
      foreach (mq[i]) if (mq[i].idx == io_read_idx) hit = 1'b1;
      if (m_wen && m_idx == io_read_idx) hit = 1'b1;
      cmp("m_req_ready", io_req_ready, 64'(mq.size() < DEPTH));
      cmp("m_read_ready", io_read_ready, 64'(!forced));
      cmp("m_read_conflict", io_read_conflict, 64'(io_read_valid && hit));
      cmp("m_busy", io_busy, 64'(mq.size() != 0 || m_wen));
      cmp("m_sram_wen", io_sram_wen, 64'(m_wen));
      cmp("m_sram_idx", io_sram_idx, 64'(m_idx));
      cmp("m_sram_way", io_sram_way_en, 64'(m_way));
      cmp("m_sram_tag", io_sram_tag, 64'(m_tag));

      if (!reset) begin
        mq.delete();
        m_starve = 0;
        m_wen = 1'b0;
        m_idx = '0;
        m_way = '0;
        m_tag = '0;
      end else begin
        issue  = (mq.size() > 0) && (!io_read_valid || forced);
        accept = io_req_valid && (mq.size() < DEPTH);
        m_wen  = 1'b0;
        if (issue) begin
          h = mq.pop_front();
          m_starve = 0;
          if (h.way != '0) begin
            m_wen = 1'b1;
            m_idx = h.idx;
            m_way = h.way;
            m_tag = {^h.tag, h.tag};
          end
        end else if (mq.size() == 0) begin
          m_starve = 0;
        end else if (m_starve < LIMIT) begin
          m_starve++;
        end
        if (accept) begin
          e.idx = io_req_bits_idx;
          e.way = io_req_bits_way_en;
          e.tag = io_req_bits_tag;
          mq.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic v, input logic [IDX_W-1:0] i, input logic [WAYS-1:0] w,
                     input logic [TAG_W-1:0] t);
    io_req_valid       = v;
    io_req_bits_idx    = i;
    io_req_bits_way_en = w;
    io_req_bits_tag    = t;
  endtask

  initial begin : stim
    int n;
    int nw;
    logic [IDX_W-1:0] wlog [4];
    int seg;

    repeat (2) @(posedge clock);
    #1;
    check_en = 1'b1;
    cmp("rst_req_ready", io_req_ready, 1);
    cmp("rst_read_ready", io_read_ready, 1);
    cmp("rst_conflict", io_read_conflict, 0);
    cmp("rst_busy", io_busy, 0);
    cmp("rst_wen", io_sram_wen, 0);
    cmp("rst_tag", io_sram_tag, 0);
    reset = 1'b1;

    // Single write with idle reads; 0xABCDEF has 17 set bits so its parity bit is 1.
    req(1, 6'h15, 8'h04, 24'hABCDEF);
    tick();
    req(0, 0, 0, 0);
    cmp("single_wen_t1", io_sram_wen, 0);
    tick();
    cmp("single_wen", io_sram_wen, 1);
    cmp("single_idx", io_sram_idx, 6'h15);
    cmp("single_way", io_sram_way_en, 8'h04);
    cmp("single_tag", io_sram_tag, 25'h1ABCDEF);
    cmp("single_busy", io_busy, 1);
    tick();
    cmp("single_busy_drop", io_busy, 0);
    cmp("single_wen_drop", io_sram_wen, 0);

    // Starvation and conflict with one queued write under continuous reads.
    io_read_valid = 1'b1;
    io_read_idx   = 6'h3F;
    req(1, 6'h03, 8'h01, 24'h000123);
    tick();
    req(0, 0, 0, 0);
    io_read_idx = 6'h03;
    #1 cmp("conf_hit", io_read_conflict, 1);
    io_read_idx = 6'h04;
    #1 cmp("conf_miss", io_read_conflict, 0);
    io_read_idx = 6'h03;
    for (int k = 1; k <= LIMIT; k++) begin
      cmp("starve_rr_high", io_read_ready, 1);
      tick();
    end
    cmp("starve_rr_low", io_read_ready, 0);
    cmp("starve_conf_queued", io_read_conflict, 1);
    tick();
    cmp("starve_wen", io_sram_wen, 1);
    cmp("starve_idx", io_sram_idx, 6'h03);
    cmp("conf_inflight", io_read_conflict, 1);
    cmp("starve_rr_back", io_read_ready, 1);
    tick();
    cmp("conf_after", io_read_conflict, 0);
    cmp("starve_wen_drop", io_sram_wen, 0);

    // Back-to-back fill under contention: third request waits for the first forced write.
    io_read_idx = 6'h3F;
    req(1, 6'h0A, 8'h02, 24'h00000A);
    cmp("fill_ready0", io_req_ready, 1);
    tick();
    req(1, 6'h0B, 8'h02, 24'h00000B);
    cmp("fill_ready1", io_req_ready, 1);
    tick();
    req(1, 6'h0C, 8'h02, 24'h00000C);
    n = 2;
    while (!io_req_ready && n < 40) begin
      tick();
      n++;
    end
    cmp("fill_ready_cycle", n, 6);
    cmp("fill_first_wen", io_sram_wen, 1);
    cmp("fill_first_idx", io_sram_idx, 6'h0A);
    tick();
    req(0, 0, 0, 0);
    nw = 0;
    for (int k = 0; k < 30; k++) begin
      if (io_sram_wen && nw < 4) begin
        wlog[nw] = io_sram_idx;
        nw++;
      end
      tick();
    end
    cmp("fill_nwrites", nw, 2);
    cmp("fill_order_b", wlog[0], 6'h0B);
    cmp("fill_order_c", wlog[1], 6'h0C);
    io_read_valid = 1'b0;
    tick();

    // A request with an empty way mask is consumed silently.
    req(1, 6'h07, 8'h00, 24'h000055);
    tick();
    req(0, 0, 0, 0);
    cmp("way0_busy", io_busy, 1);
    tick();
    cmp("way0_wen", io_sram_wen, 0);
    cmp("way0_busy_drop", io_busy, 0);
    cmp("way0_ready", io_req_ready, 1);
    cmp("way0_idx_held", io_sram_idx, 6'h0C);

    // Reset with two entries queued discards them.
    io_read_valid = 1'b1;
    req(1, 6'h21, 8'h01, 24'h111111);
    tick();
    req(1, 6'h22, 8'h01, 24'h222222);
    tick();
    cmp("rst2_full", io_req_ready, 0);
    reset = 1'b0;
    req(1, 6'h23, 8'h01, 24'h333333);
    tick();
    reset = 1'b1;
    req(0, 0, 0, 0);
    io_read_valid = 1'b0;
    cmp("rst2_ready", io_req_ready, 1);
    cmp("rst2_busy", io_busy, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      cmp("rst2_no_wen", io_sram_wen, 0);
    end

    // Randomized traffic with varying read pressure, occasional resets.
    for (int c = 0; c < 3000; c++) begin
      seg = (c / 200) % 4;
      reset = ($urandom_range(0, 299) != 0);
      io_req_valid = ($urandom_range(0, 2) != 0);
      io_req_bits_idx = IDX_W'($urandom_range(0, 7));
      io_req_bits_way_en = ($urandom_range(0, 5) == 0) ? 8'h00 : WAYS'(1 << $urandom_range(0, 7));
      io_req_bits_tag = TAG_W'($urandom);
      case (seg)
        0:       io_read_valid = 1'b0;
        1:       io_read_valid = ($urandom_range(0, 9) < 3);
        2:       io_read_valid = ($urandom_range(0, 9) < 7);
        default: io_read_valid = 1'b1;
      endcase
      io_read_idx = IDX_W'($urandom_range(0, 7));
      tick();
    end

    reset = 1'b1;
    io_req_valid = 1'b0;
    io_read_valid = 1'b0;
    tick();
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
